fea_sequencer: RTL and testbench

FEA_SEQUENCER -- requirements
Module: fea_sequencer

---
 rtl/fea_pkg.sv | 21 ++
 rtl/fea_cmd_demux.sv | 24 ++
 rtl/fea_sequencer.sv | 153 +++++++++++++++
 tb/tb_fea_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fea_pkg.sv
// Shared command codes, FSM states and command type for the
// FEA mesh sequencer and its node block.
package fea_pkg;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_WR_PROTECT = 3'd0;
  localparam cmd_t CMD_SET_NODE   = 3'd1;
  localparam cmd_t CMD_SET_POS    = 3'd2;
  localparam cmd_t CMD_RUN        = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_POS,
    S_LOAD_VAL,
    S_RUN,
    S_READBACK,
    S_DONE
  } state_t;

endpackage

// File: rtl/fea_cmd_demux.sv
// Expands one (index, command, broadcast) triple into the packed
// per-node command vector; unaddressed nodes get WR_PROTECT.
module fea_cmd_demux
  import fea_pkg::*;
#(
  parameter int NUM_NODES = 8,
  parameter int IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic [IDX_W-1:0]       idx,
  input  cmd_t                   cmd,
  input  logic                   bcast,
  output logic [3*NUM_NODES-1:0] node_cmd
);

  always_comb begin
    node_cmd = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (bcast || idx == IDX_W'(i)) begin
        node_cmd[3*i +: 3] = cmd;
      end
    end
  end

endmodule

// File: rtl/fea_sequencer.sv
// FEA mesh job sequencer: load positions/values, run, read back.
// Optional readback stream enabled by FEA_SEQ_READBACK_EN.
module fea_sequencer
  import fea_pkg::*;
#(
  parameter int NUM_NODES = 8,
  parameter int STEP_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [STEP_W-1:0]       steps,
  input  logic                    init_valid,
  output logic                    init_ready,
  input  logic [31:0]             init_data,
  output logic [3*NUM_NODES-1:0]  node_cmd,
  output logic [31:0]             set_val,
  input  logic [32*NUM_NODES-1:0] nodeval_bus,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W =
    (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_NODES - 1);

`ifdef FEA_SEQ_READBACK_EN
  localparam state_t POST_RUN = S_READBACK;
`else
  localparam state_t POST_RUN = S_DONE;
`endif

  state_t            state;
  state_t            state_nx;
  logic [STEP_W-1:0] cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nx;
  cmd_t              cmd_q;
  logic [IDX_W-1:0]  idx_q;
  logic              bcast_q;
  logic              load_acc;
  logic              rd_acc;
  logic              idx_last;

  assign load_acc = init_valid & init_ready;
  assign rd_acc   = out_valid & out_ready;
  assign idx_last = (idx == LAST);
  assign idx_nx   = idx_last ? '0 : idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD_POS;
      end
      S_LOAD_POS: begin
        if (load_acc && idx_last) state_nx = S_LOAD_VAL;
      end
      S_LOAD_VAL: begin
        if (load_acc && idx_last) begin
          state_nx = (cnt != '0) ? S_RUN : POST_RUN;
        end
      end
      S_RUN: begin
        if (cnt == '0) state_nx = POST_RUN;
      end
      S_READBACK: begin
        if (rd_acc && idx_last) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    init_ready = (state == S_LOAD_POS) ||
                 (state == S_LOAD_VAL);
`ifdef FEA_SEQ_READBACK_EN
    out_valid  = (state == S_READBACK);
`else
    out_valid  = 1'b0;
`endif
    out_data   = out_valid ? nodeval_bus[32*idx +: 32] : '0;
  end

  // Load commands are registered so set_val and node_cmd line up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      cmd_q   <= CMD_WR_PROTECT;
      idx_q   <= '0;
      bcast_q <= 1'b0;
      set_val <= '0;
    end else begin
      cmd_q   <= CMD_WR_PROTECT;
      bcast_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= steps;
            idx <= '0;
          end
        end
        S_LOAD_POS, S_LOAD_VAL: begin
          if (load_acc) begin
            set_val <= init_data;
            cmd_q   <= (state == S_LOAD_POS) ?
                       CMD_SET_POS : CMD_SET_NODE;
            idx_q   <= idx;
            idx     <= idx_nx;
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            cmd_q   <= CMD_RUN;
            bcast_q <= 1'b1;
            cnt     <= cnt - STEP_W'(1);
          end
        end
        S_READBACK: begin
          if (rd_acc) idx <= idx_nx;
        end
        default: ;
      endcase
    end
  end

  fea_cmd_demux #(
    .NUM_NODES (NUM_NODES),
    .IDX_W     (IDX_W)
  ) u_demux (
    .idx      (idx_q),
    .cmd      (cmd_q),
    .bcast    (bcast_q),
    .node_cmd (node_cmd)
  );

endmodule

// File: tb/tb_fea_sequencer.sv
// Self-checking bench for fea_sequencer with NUM_NODES=4; works
// with or without FEA_SEQ_READBACK_EN.
module tb_fea_sequencer;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam logic [11:0] ALL_RUN = 12'h6DB;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [SW-1:0]   steps = '0;
  logic            init_valid = 1'b0;
  logic            init_ready;
  logic [31:0]     init_data = '0;
  logic [3*N-1:0]  node_cmd;
  logic [31:0]     set_val;
  logic [32*N-1:0] nodeval_bus = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_data;
  logic            busy;
  logic            done;

  fea_sequencer #(.NUM_NODES(N), .STEP_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .steps       (steps),
    .init_valid  (init_valid),
    .init_ready  (init_ready),
    .init_data   (init_data),
    .node_cmd    (node_cmd),
    .set_val     (set_val),
    .nodeval_bus (nodeval_bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] cmd;
    logic [31:0] val;
    bit          chk;
  } ev_t;

  ev_t         exp_cmd[$];
  logic [31:0] exp_rd[$];
  ev_t         ev_pop;
  logic [31:0] rd_pop;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int streak = 0;
  int last_streak = 0;
  int last_run_cyc = -1;
  int first_acc_cyc = -1;
  int last_acc_cyc = -1;
  int done_cyc = -1;
  int done_seen = 0;
  bit ov_seen = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic [31:0] first_rd = '0;

  logic [31:0] jpos[4];
  logic [31:0] jval[4];
  int jsteps;
  bit jstall;
  bit jtog;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every non-WR_PROTECT cycle must match the next
  // expected command, every accepted beat the next node word.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (node_cmd !== '0) begin
        if (exp_cmd.size() == 0) begin
          chk("unexpected_cmd", 64'(node_cmd), 64'd0);
        end else begin
          ev_pop = exp_cmd.pop_front();
          chk("node_cmd", 64'(node_cmd), 64'(ev_pop.cmd));
          if (ev_pop.chk)
            chk("set_val", 64'(set_val), 64'(ev_pop.val));
        end
      end
      if (node_cmd === ALL_RUN) begin
        streak++;
        last_run_cyc = cyc;
      end else if (streak > 0) begin
        last_streak = streak;
        streak = 0;
      end
      if (out_valid) ov_seen = 1;
      if (prev_stall && out_valid)
        chk("out_stable", 64'(out_data), 64'(prev_data));
      if (out_valid && out_ready) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_beat", 64'(out_data), 64'd0);
        end else begin
          rd_pop = exp_rd.pop_front();
          chk("out_data", 64'(out_data), 64'(rd_pop));
        end
        if (first_acc_cyc < 0) begin
          first_acc_cyc = cyc;
          first_rd = out_data;
        end
        last_acc_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end else begin
      streak = 0;
      prev_stall = 0;
    end
  end

  task automatic load_job();
    ev_t e;
    bit got;
    for (int k = 0; k < 4; k++) begin
      e.cmd = 12'h002 << (3*k);
      e.val = jpos[k];
      e.chk = 1;
      exp_cmd.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      e.cmd = 12'h001 << (3*k);
      e.val = jval[k];
      e.chk = 1;
      exp_cmd.push_back(e);
    end
    for (int k = 0; k < jsteps; k++) begin
      e.cmd = ALL_RUN;
      e.val = '0;
      e.chk = 0;
      exp_cmd.push_back(e);
    end
`ifdef FEA_SEQ_READBACK_EN
    for (int k = 0; k < N; k++)
      exp_rd.push_back(nodeval_bus[32*k +: 32]);
`endif
    last_streak = 0;
    done_seen = 0;
    first_acc_cyc = -1;
    last_acc_cyc = -1;
    last_run_cyc = -1;
    done_cyc = -1;
    ov_seen = 0;
    steps = SW'(jsteps);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2 && jstall) begin
        init_valid = 1'b0;
        repeat (5) tick();
      end
      init_valid = 1'b1;
      init_data = (k < 4) ? jpos[k] : jval[k-4];
      got = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (init_ready) begin
          got = 1;
          break;
        end
      end
      if (!got) chk("load_timeout", 64'd0, 64'd1);
      tick();
    end
    init_valid = 1'b0;
  endtask

  task automatic finish_job();
    bit got;
    got = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_seen > 0) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #1;
      out_ready = jtog ? ~out_ready : 1'b1;
    end
    chk("done_timeout", 64'(got), 64'd1);
    @(negedge clk);
    chk("done_pulse_len", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("cmd_left", 64'(exp_cmd.size()), 64'd0);
    chk("rd_left", 64'(exp_rd.size()), 64'd0);
    chk("run_streak", 64'(last_streak), 64'(jsteps));
    chk("done_count", 64'(done_seen), 64'd1);
`ifdef FEA_SEQ_READBACK_EN
    chk("done_after_rd", 64'(done_cyc), 64'(last_acc_cyc + 1));
    if (!jtog)
      chk("rd_consec", 64'(last_acc_cyc - first_acc_cyc), 64'd3);
`else
    if (jsteps > 0)
      chk("done_after_run", 64'(done_cyc),
          64'(last_run_cyc + 1));
    chk("no_out_valid", 64'(ov_seen), 64'd0);
`endif
    out_ready = 1'b1;
    tick();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_node_cmd"}, 64'(node_cmd), 64'd0);
    chk({tag, "_set_val"}, 64'(set_val), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_init_ready"}, 64'(init_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    bit got;
    nodeval_bus = {32'd4, 32'd3, 32'd2, 32'd1};
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    reset_checks("rst");
    tick();
    rst_n = 1'b1;
    tick();

    jpos = '{32'd0, 32'd10, 32'd20, 32'd30};
    jval = '{32'd100, 32'd0, 32'd0, 32'd0};
    jsteps = 3; jstall = 0; jtog = 0;
    load_job();
    finish_job();
`ifdef FEA_SEQ_READBACK_EN
    chk("first_rd", 64'(first_rd), 64'd1);
`endif

    nodeval_bus = {32'd40, 32'd30, 32'd20, 32'd10};
    jpos = '{32'd5, 32'd6, 32'd7, 32'd8};
    jval = '{32'd9, 32'd10, 32'd11, 32'd12};
    jsteps = 0; jstall = 0; jtog = 1;
    load_job();
    finish_job();

    jpos = '{32'h11, 32'h22, 32'h33, 32'h44};
    jval = '{32'hA, 32'hB, 32'hC, 32'hD};
    jsteps = 1; jstall = 1; jtog = 0;
    load_job();
    finish_job();

    jpos = '{32'd1, 32'd2, 32'd3, 32'd4};
    jval = '{32'd5, 32'd6, 32'd7, 32'd8};
    jsteps = 10; jstall = 0; jtog = 0;
    load_job();
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (streak == 2) begin
        got = 1;
        break;
      end
    end
    chk("run2_timeout", 64'(got), 64'd1);
    exp_cmd.delete();
    exp_rd.delete();
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    tick();
    rst_n = 1'b1;
    tick();

    jpos = '{32'd7, 32'd8, 32'd9, 32'd10};
    jval = '{32'd70, 32'd80, 32'd90, 32'd100};
    jsteps = 2; jstall = 0; jtog = 0;
    load_job();
    finish_job();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
